gcd_share_ctrl: RTL and testbench
=================================

// Module: gcd_share_ctrl
// PURPOSE
//  Shares one iterative GCD/fraction-reduce engine between two requesters (two operand panels).
//  - Arbitrates round-robin and latches the granted requester's operand pair.
//  - Sequences subtractive Euclid, then reduces both operands by the GCD.
//  - Returns the GCD and the reduced pair with a one-cycle done pulse.
//  Sits between the front-panel input logic and the 7-segment result path.
// PARAMETERS
//  W   4   operand/result width, unsigned
// PORTS
//  clk      in   1   single clock, rising edge
//  rst      in   1   asynchronous, active-high reset
//  req      in   2   req[i]: requester i wants service; held high until done[i]
//  a0, b0   in   W   operand pair, requester 0
//  a1, b1   in   W   operand pair, requester 1
//  gnt      out  2   one-hot; high from grant cycle through DONE cycle
//  busy     out  1   high in any state except IDLE
//  done     out  2   one-cycle pulse to the served requester; results valid that cycle and held after
//  gcd_out  out  W   GCD of the served pair
//  res_a    out  W   a / gcd
//  res_b    out  W   b / gcd
//  err      out  1   registered with done; high when a = b = 0
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0; state IDLE; rr pointer set so req0 wins the first tie.
//  States: IDLE -> LOAD -> GCD -> DIV -> DONE -> IDLE.
//  IDLE:
//  - If any req: set gnt one-hot and go to LOAD.
//  - One req high: grant it. Both high: grant the one not served last.
//  - Pointer updates on grant.
//  LOAD: latch x = a_i, y = b_i, and keep copies ra = a_i, rb = b_i. Operands are sampled only here.
//  GCD (one step per cycle):
//  - x = y = 0: err = 1, g = 0, go to DONE.
//  - x = 0 or y = 0: g = nonzero value, go to DIV.
//  - x = y: g = x, go to DIV.
//  - x > y: x <= x - y. Otherwise y <= y - x.
//  DIV (both operands in parallel, one step per cycle):
//  - If ra >= g: ra <= ra - g, qa <= qa + 1.
//  - Same rule for rb / qb.
//  - Leave when ra < g and rb < g.
//  DONE:
//  - Assert done[i] for exactly 1 cycle.
//  - Register gcd_out = g, res_a = qa, res_b = qb, err.
//  - Drop gnt, then go to IDLE.
//  - Result outputs hold until the next DONE.
//  Zero operand: gcd(a, 0) = a, so res_a = 1 and res_b = 0. err case: res_a = res_b = gcd_out = 0.
//  Widths: all arithmetic W bits. Subtractions are guarded by compares, so no wrap.
//  Quotient counters cannot exceed 2^W - 1 (g >= 1).
//  Latency: worst case for W = 4 is well under 40 cycles. Requester must not assume a fixed latency.
//  Handshake:
//  - req dropped mid-operation: the operation still completes, and done still pulses.
//  - req still high after done: treated as a new request in the next IDLE cycle, subject to round-robin.
//  - Requests arriving while busy wait; none are lost while req is held.
//  - A requester never gets back-to-back service while the other is waiting.
//  Reset mid-operation: aborts at once, with no done pulse. The operation restarts only if req is reasserted.
// STRUCTURE
//  Shared package gcd_pkg:
//  - State encoding localparams: IDLE, LOAD, GCD, DIV, DONE.
//  - Default W.
//  Sub-module rr_arb2: 2-way round-robin arbiter.
//  - Inputs: req[1:0], grant_en.
//  - Outputs: one-hot gnt, pointer register.
//  Engine datapath (x, y, ra, rb, qa, qb, g) and the FSM stay in this module.
// TESTING
//  1. req = 01, a0 = 6, b0 = 4 -> done = 01 once; gcd_out = 2, res_a = 3, res_b = 2, err = 0; gnt = 01 until done.
//  2. req = 11 from reset, a0 = 9, b0 = 6, a1 = 8, b1 = 12
//     -> req0 served first (gcd 3, 3/2), then req1 (gcd 4, 2/3); gnt never 11.
//  3. a0 = 0, b0 = 0 -> err = 1, gcd_out = res_a = res_b = 0.
//     a0 = 7, b0 = 0 -> gcd 7, res 1/0, err = 0.
//  4. a0 = 15, b0 = 15 -> gcd 15, res 1/1.
//     a0 = 13, b0 = 1 -> gcd 1, res 13/1, no wrap.
//  5. Assert rst during GCD state -> outputs 0, busy 0 same cycle, no done pulse.
//     Re-request a0 = 6, b0 = 4 -> correct result.
//  6. Change a0 and drop req0 during DIV -> result still from the latched operands; done[0] still pulses.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the shared GCD / fraction-reduce engine.
//   W_DEF   : default operand/result width (unsigned)
//   state_t : engine sequencer states
package gcd_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        GCD  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : request lines
//   grant_en  : arbitration cycle; the pointer advances only when this is high
//   gnt[1:0]  : one-hot winner (combinational), all zero when no request
//   ptr       : index of the requester served last
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output logic       ptr
);

    // On a tie, the requester that was not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b1;
        end else if (grant_en && (req != 2'b00)) begin
            // NOTE: sequential state uses non-blocking assignments only.
            ptr <= gnt[1];
        end
    end

endmodule

// File: rtl/gcd_share_ctrl.sv
// Shares one iterative GCD / fraction-reduce engine between two requesters.
// Subtractive Euclid finds g, then both operands are divided by g through
// repeated subtraction. Results come back with a one-cycle done pulse.
//   clk, rst        : clock, asynchronous active-high reset
//   req[1:0]        : service requests, held until done[i]
//   a0, b0 / a1, b1 : operand pairs of requester 0 / 1
//   gnt[1:0]        : one-hot owner of the engine, from LOAD through DONE
//   busy            : engine not idle
//   done[1:0]       : one-cycle pulse to the served requester
//   gcd_out         : gcd(a, b)
//   res_a, res_b    : a / gcd, b / gcd
//   err             : a = b = 0 (all results zero)
module gcd_share_ctrl
    import gcd_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [1:0]   done,
    output logic [W-1:0] gcd_out,
    output logic [W-1:0] res_a,
    output logic [W-1:0] res_b,
    output logic         err
);

    state_t       state, state_n;
    logic [1:0]   arb_gnt;
    logic         arb_ptr;
    logic [1:0]   gnt_q;
    logic [W-1:0] x, y, ra, rb, qa, qb, g;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant_en (state == IDLE),
        .gnt      (arb_gnt),
        .ptr      (arb_ptr)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req != 2'b00) state_n = LOAD;
            LOAD: state_n = GCD;
            GCD: begin
                if (x == '0 && y == '0)                    state_n = DONE;
                else if (x == '0 || y == '0 || x == y)     state_n = DIV;
            end
            DIV:  if (ra < g && rb < g) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Engine datapath. Result registers load on the transition into DONE so
    // they are already valid during the done pulse, and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q   <= '0;
            x       <= '0;
            y       <= '0;
            ra      <= '0;
            rb      <= '0;
            qa      <= '0;
            qb      <= '0;
            g       <= '0;
            gcd_out <= '0;
            res_a   <= '0;
            res_b   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) gnt_q <= arb_gnt;
                end
                LOAD: begin
                    // The only cycle the operand inputs are sampled.
                    x  <= gnt_q[1] ? a1 : a0;
                    y  <= gnt_q[1] ? b1 : b0;
                    ra <= gnt_q[1] ? a1 : a0;
                    rb <= gnt_q[1] ? b1 : b0;
                    qa <= '0;
                    qb <= '0;
                    g  <= '0;
                end
                GCD: begin
                    if (x == '0 && y == '0) begin
                        g       <= '0;
                        gcd_out <= '0;
                        res_a   <= '0;
                        res_b   <= '0;
                        err     <= 1'b1;
                    end else if (x == '0) begin
                        g <= y;
                    end else if (y == '0 || x == y) begin
                        g <= x;
                    end else if (x > y) begin
                        x <= x - y;
                    end else begin
                        y <= y - x;
                    end
                end
                DIV: begin
                    if (ra < g && rb < g) begin
                        gcd_out <= g;
                        res_a   <= qa;
                        res_b   <= qb;
                        err     <= 1'b0;
                    end else begin
                        if (ra >= g) begin
                            ra <= ra - g;
                            qa <= qa + 1'b1;
                        end
                        if (rb >= g) begin
                            rb <= rb - g;
                            qb <= qb + 1'b1;
                        end
                    end
                end
                DONE: gnt_q <= '0;
                default: gnt_q <= '0;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state != IDLE);
    assign done = (state == DONE) ? gnt_q : 2'b00;

endmodule

// File: tb/tb_gcd_share_ctrl.sv
module tb_gcd_share_ctrl;

    localparam int W = 4;

    typedef struct packed {
        logic [1:0]   done;
        logic [W-1:0] g;
        logic [W-1:0] qa;
        logic [W-1:0] qb;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         busy;
    logic [1:0]   done;
    logic [W-1:0] gcd_out, res_a, res_b;
    logic         err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    gcd_share_ctrl #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .res_a   (res_a),
        .res_b   (res_b),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) check("gnt_onehot0", int'($onehot0(gnt)), 1);
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_idx", int'(done), int'(e.done));
                    check("gnt_at_done", int'(gnt), int'(e.done));
                    check("busy_at_done", int'(busy), 1);
                    check("gcd_out", int'(gcd_out), int'(e.g));
                    check("res_a", int'(res_a), int'(e.qa));
                    check("res_b", int'(res_b), int'(e.qb));
                    check("err", int'(err), int'(e.err));
                end
            end
        end
    end

    task automatic push(input logic [1:0] d, input int g, input int qa, input int qb, input logic e);
        exp_t x;
        x.done = d;
        x.g    = W'(g);
        x.qa   = W'(qa);
        x.qb   = W'(qb);
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int idx);
        bit seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk); #1;
            if (done[idx]) seen = 1'b1;
        end
        if (!seen) check("done_timeout", int'(done), 1 << idx);
    endtask

    // Single request from requester 0; req dropped in the done cycle.
    task automatic run0(input int a, input int b, input int g, input int qa, input int qb, input logic e);
        a0 = W'(a);
        b0 = W'(b);
        push(2'b01, g, qa, qb, e);
        req = 2'b01;
        wait_done(0);
        req = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();

        // Reset state
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_gcd", int'(gcd_out), 0);
        check("rst_res_a", int'(res_a), 0);
        check("rst_res_b", int'(res_b), 0);
        check("rst_err", int'(err), 0);

        // Test 1: basic request, grant visible right after arbitration
        a0 = 4'd6; b0 = 4'd4;
        push(2'b01, 2, 3, 2, 1'b0);
        req = 2'b01;
        @(posedge clk); #1;
        check("t1_gnt", int'(gnt), 1);
        check("t1_busy", int'(busy), 1);
        wait_done(0);
        req = 2'b00;
        @(posedge clk); #1;
        check("t1_gnt_dropped", int'(gnt), 0);
        check("t1_busy_dropped", int'(busy), 0);
        check("t1_hold_gcd", int'(gcd_out), 2);

        // Test 2: simultaneous requests from reset; req0 held to see alternation
        do_reset();
        a0 = 4'd9; b0 = 4'd6; a1 = 4'd8; b1 = 4'd12;
        push(2'b01, 3, 3, 2, 1'b0);
        push(2'b10, 4, 2, 3, 1'b0);
        push(2'b01, 3, 3, 2, 1'b0);
        req = 2'b11;
        wait_done(0);
        wait_done(1);
        req = 2'b01;
        wait_done(0);
        req = 2'b00;
        @(posedge clk); #1;

        // Test 3: zero operands
        run0(0, 0, 0, 0, 0, 1'b1);
        run0(7, 0, 7, 1, 0, 1'b0);
        run0(0, 5, 5, 0, 1, 1'b0);

        // Test 4: boundary operands
        run0(15, 15, 15, 1, 1, 1'b0);
        run0(13, 1, 1, 13, 1, 1'b0);

        // Test 5: reset in the middle of the GCD phase
        a0 = 4'd13; b0 = 4'd1;
        req = 2'b01;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        req = 2'b00;
        #1;
        check("t5_busy", int'(busy), 0);
        check("t5_gnt", int'(gnt), 0);
        check("t5_done", int'(done), 0);
        check("t5_gcd", int'(gcd_out), 0);
        check("t5_res_a", int'(res_a), 0);
        check("t5_err", int'(err), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t5_idle_after", int'(busy), 0);
        run0(6, 4, 2, 3, 2, 1'b0);

        // Test 6: operands changed and req dropped while dividing
        a0 = 4'd15; b0 = 4'd5;
        push(2'b01, 5, 3, 1, 1'b0);
        req = 2'b01;
        repeat (6) @(posedge clk);
        #1;
        a0 = 4'd2; b0 = 4'd9;
        req = 2'b00;
        wait_done(0);
        @(posedge clk); #1;

        repeat (3) @(posedge clk); #1;
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
